// File: rtl/fir_tap_feeder.sv
// Serial-to-window feeder for the 6-tap combinational FIR datapath, with a
// registered valid/ready result stage (tap window -> output register).
module fir_tap_feeder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RES_WIDTH = 35,
  parameter bit          PRIME     = 1'b0,
  parameter bit          FLUSH     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_last,
  output logic [WIDTH-1:0]     tap_0,
  output logic [WIDTH-1:0]     tap_1,
  output logic [WIDTH-1:0]     tap_2,
  output logic [WIDTH-1:0]     tap_3,
  output logic [WIDTH-1:0]     tap_4,
  output logic [WIDTH-1:0]     tap_5,
  input  logic [RES_WIDTH-1:0] dp_result,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RES_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 short_blk
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] taps [6];
  logic             win_valid, win_last;
  logic [2:0]       fill_cnt, fill_nxt;
  logic [2:0]       flush_cnt, flush_nxt;

  logic load_out, shift_ok, accept;
  logic shift, shift_zero, shift_fresh, shift_valid, shift_last;
  logic clr_taps, short_nxt;

  assign load_out = win_valid && (!m_valid || m_ready);
  assign shift_ok = !win_valid || load_out;
  assign s_ready  = (state != ST_FLUSH) && shift_ok && !rst;
  assign accept   = s_valid && s_ready;
  assign busy     = (state != ST_IDLE);

  assign tap_0 = taps[0];
  assign tap_1 = taps[1];
  assign tap_2 = taps[2];
  assign tap_3 = taps[3];
  assign tap_4 = taps[4];
  assign tap_5 = taps[5];

  always_comb begin
    state_nxt   = state;
    fill_nxt    = fill_cnt;
    flush_nxt   = flush_cnt;
    shift       = 1'b0;
    shift_zero  = 1'b0;
    shift_fresh = 1'b0;
    shift_valid = 1'b0;
    shift_last  = 1'b0;
    clr_taps    = 1'b0;
    short_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (PRIME) begin
            if (s_last && !FLUSH) begin
              short_nxt = 1'b1;
              clr_taps  = 1'b1;
            end else begin
              shift       = 1'b1;
              shift_fresh = 1'b1;
              fill_nxt    = s_last ? 3'd0 : 3'd1;
              state_nxt   = s_last ? ST_FLUSH : ST_FILL;
            end
          end else begin
            shift       = 1'b1;
            shift_fresh = 1'b1;
            shift_valid = 1'b1;
            if (s_last) begin
              if (FLUSH) state_nxt = ST_FLUSH;
              else       shift_last = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end else if (shift_ok) begin
          // taps are cleared only once the final window has left the window stage
          clr_taps = 1'b1;
        end
      end

      ST_FILL: begin
        if (accept) begin
          if (fill_cnt == 3'd5) begin
            shift       = 1'b1;
            shift_valid = 1'b1;
            fill_nxt    = 3'd0;
            if (s_last) begin
              if (FLUSH) begin
                state_nxt = ST_FLUSH;
              end else begin
                state_nxt  = ST_IDLE;
                shift_last = 1'b1;
              end
            end else begin
              state_nxt = ST_RUN;
            end
          end else if (s_last) begin
            fill_nxt = 3'd0;
            if (FLUSH) begin
              shift     = 1'b1;
              state_nxt = ST_FLUSH;
            end else begin
              clr_taps  = 1'b1;
              short_nxt = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else begin
            shift    = 1'b1;
            fill_nxt = fill_cnt + 3'd1;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          shift       = 1'b1;
          shift_valid = 1'b1;
          if (s_last) begin
            if (FLUSH) begin
              state_nxt = ST_FLUSH;
            end else begin
              state_nxt  = ST_IDLE;
              shift_last = 1'b1;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (shift_ok) begin
          shift       = 1'b1;
          shift_zero  = 1'b1;
          shift_valid = 1'b1;
          if (flush_cnt == 3'd4) begin
            flush_nxt  = 3'd0;
            shift_last = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            flush_nxt = flush_cnt + 3'd1;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fill_cnt  <= '0;
      flush_cnt <= '0;
      taps      <= '{default: '0};
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      short_blk <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_nxt;
      flush_cnt <= flush_nxt;
      short_blk <= short_nxt;

      if (clr_taps) begin
        taps <= '{default: '0};
      end else if (shift) begin
        for (int unsigned k = 1; k < 6; k++) begin
          taps[k] <= shift_fresh ? '0 : taps[k-1];
        end
        taps[0] <= shift_zero ? '0 : s_data;
      end

      if (shift) begin
        win_valid <= shift_valid;
        win_last  <= shift_last;
      end else if (load_out) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end

      if (load_out) begin
        m_valid <= 1'b1;
        m_data  <= dp_result;
        m_last  <= win_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Directed bench for fir_tap_feeder; the datapath is modelled as the plain sum
// of the six taps. Instance a: PRIME=0/FLUSH=1, instance b: PRIME=1/FLUSH=0.
module tb_fir_tap_feeder;
  localparam int W  = 16;
  localparam int RW = 35;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, s_valid, s_last, m_ready, sel;
  logic [W-1:0]  s_data;

  logic          a_s_ready, a_m_valid, a_m_last, a_busy, a_short;
  logic [RW-1:0] a_dp, a_m_data;
  logic [W-1:0]  a_tap [6];
  logic          b_s_ready, b_m_valid, b_m_last, b_busy, b_short;
  logic [RW-1:0] b_dp, b_m_data;
  logic [W-1:0]  b_tap [6];
  logic          a_s_valid, b_s_valid;

  assign a_s_valid = s_valid && !sel;
  assign b_s_valid = s_valid && sel;
  assign a_dp = RW'(a_tap[0]) + RW'(a_tap[1]) + RW'(a_tap[2]) + RW'(a_tap[3]) + RW'(a_tap[4]) + RW'(a_tap[5]);
  assign b_dp = RW'(b_tap[0]) + RW'(b_tap[1]) + RW'(b_tap[2]) + RW'(b_tap[3]) + RW'(b_tap[4]) + RW'(b_tap[5]);

  fir_tap_feeder #(.WIDTH(W), .RES_WIDTH(RW), .PRIME(1'b0), .FLUSH(1'b1)) u_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(s_data), .s_last(s_last),
    .tap_0(a_tap[0]), .tap_1(a_tap[1]), .tap_2(a_tap[2]), .tap_3(a_tap[3]), .tap_4(a_tap[4]), .tap_5(a_tap[5]),
    .dp_result(a_dp), .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .m_last(a_m_last),
    .busy(a_busy), .short_blk(a_short));

  fir_tap_feeder #(.WIDTH(W), .RES_WIDTH(RW), .PRIME(1'b1), .FLUSH(1'b0)) u_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(s_data), .s_last(s_last),
    .tap_0(b_tap[0]), .tap_1(b_tap[1]), .tap_2(b_tap[2]), .tap_3(b_tap[3]), .tap_4(b_tap[4]), .tap_5(b_tap[5]),
    .dp_result(b_dp), .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .busy(b_busy), .short_blk(b_short));

  logic          cur_s_ready, cur_m_valid, cur_m_last, cur_short;
  logic [RW-1:0] cur_m_data;
  assign cur_s_ready = sel ? b_s_ready : a_s_ready;
  assign cur_m_valid = sel ? b_m_valid : a_m_valid;
  assign cur_m_last  = sel ? b_m_last  : a_m_last;
  assign cur_m_data  = sel ? b_m_data  : a_m_data;
  assign cur_short   = sel ? b_short   : a_short;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } smp_t;

  smp_t          in_q [$];
  logic [RW-1:0] got_d [$];
  logic          got_l [$];
  int            got_c [$];
  int            acc_c [$];
  int            cyc, sb_cnt, mv_cnt;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic push(input int d, input logic l);
    smp_t s;
    s.d = W'(d);
    s.l = l;
    in_q.push_back(s);
  endtask

  task automatic clear_logs();
    got_d.delete(); got_l.delete(); got_c.delete(); acc_c.delete();
    sb_cnt = 0; mv_cnt = 0;
  endtask

  // Called at a negedge: drive the head sample, log handshakes that the next edge completes.
  task automatic step();
    smp_t dummy;
    if (in_q.size() != 0) begin
      s_valid = 1'b1; s_data = in_q[0].d; s_last = in_q[0].l;
    end else begin
      s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    end
    #1;
    if (s_valid && cur_s_ready) begin
      dummy = in_q.pop_front();
      acc_c.push_back(cyc);
    end
    if (cur_m_valid) mv_cnt++;
    if (cur_m_valid && m_ready) begin
      got_d.push_back(cur_m_data); got_l.push_back(cur_m_last); got_c.push_back(cyc);
    end
    if (cur_short) sb_cnt++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1; sel = 1'b0; cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready_in_rst: got %0b want 0", a_s_ready); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (a_m_valid !== 1'b0 || b_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b/%0b want 0/0", a_m_valid, b_m_valid); end
    n_cmp++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_short !== 1'b0 || b_short !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_short: got %0b%0b%0b%0b want 0000", a_busy, b_busy, a_short, b_short);
    end
    n_cmp++;
    if (a_m_data !== '0 || a_m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_data: got %0d/%0b want 0/0", a_m_data, a_m_last); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (a_tap[k] !== '0 || b_tap[k] !== '0) begin n_fail++; $display("FAIL reset_tap%0d: got %0d/%0d want 0", k, a_tap[k], b_tap[k]); end
    end
    n_cmp++;
    if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %0b/%0b want 1/1", a_s_ready, b_s_ready); end
  endtask

  task automatic test_stream_flush();
    int exp_d [8] = '{1, 3, 6, 6, 6, 6, 5, 3};
    sel = 1'b0; m_ready = 1'b1; clear_logs();
    push(1, 1'b0); push(2, 1'b0); push(3, 1'b1);
    repeat (14) step();
    n_cmp++;
    if (got_d.size() != 8) begin n_fail++; $display("FAIL flush_count: got %0d want 8", got_d.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= got_d.size() || got_d[i] !== RW'(exp_d[i]) || got_l[i] !== (i == 7)) begin
        n_fail++;
        $display("FAIL flush_res[%0d]: got %0d last %0b want %0d last %0b", i,
                 (i < got_d.size()) ? got_d[i] : '0, (i < got_l.size()) ? got_l[i] : 1'b0, exp_d[i], (i == 7));
      end
      n_cmp++;
      if (i >= got_c.size() || got_c[i] != got_c[0] + i) begin n_fail++; $display("FAIL flush_consecutive[%0d]: result not on consecutive cycle", i); end
    end
    n_cmp++;
    if (acc_c.size() != 3 || got_c.size() == 0 || got_c[0] != acc_c[0] + 2) begin
      n_fail++; $display("FAIL flush_latency: accepts %0d, first result cycle offset wrong", acc_c.size());
    end
    n_cmp++;
    if (a_busy !== 1'b0 || a_tap[0] !== '0 || a_tap[5] !== '0) begin
      n_fail++; $display("FAIL flush_idle: got busy %0b tap0 %0d tap5 %0d want 0 0 0", a_busy, a_tap[0], a_tap[5]);
    end
  endtask

  task automatic test_backpressure();
    int exp_d [9] = '{10, 30, 60, 100, 100, 100, 90, 70, 40};
    int hold_bad = 0;
    sel = 1'b0; m_ready = 1'b0; clear_logs();
    push(10, 1'b0); push(20, 1'b0); push(30, 1'b0); push(40, 1'b1);
    repeat (6) begin
      step();
      if (a_m_valid && (a_m_data !== RW'(10) || a_m_last !== 1'b0)) hold_bad++;
    end
    n_cmp++;
    if (hold_bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); end
    n_cmp++;
    if (acc_c.size() != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", acc_c.size()); end
    n_cmp++;
    if (a_s_ready !== 1'b0 || a_m_valid !== 1'b1 || a_m_data !== RW'(10)) begin
      n_fail++; $display("FAIL bp_stall: got s_ready %0b m_valid %0b m_data %0d want 0 1 10", a_s_ready, a_m_valid, a_m_data);
    end
    m_ready = 1'b1;
    repeat (16) step();
    n_cmp++;
    if (got_d.size() != 9) begin n_fail++; $display("FAIL bp_count: got %0d want 9", got_d.size()); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (i >= got_d.size() || got_d[i] !== RW'(exp_d[i]) || got_l[i] !== (i == 8)) begin
        n_fail++;
        $display("FAIL bp_res[%0d]: got %0d want %0d", i, (i < got_d.size()) ? got_d[i] : '0, exp_d[i]);
      end
    end
    n_cmp++;
    if (in_q.size() != 0) begin n_fail++; $display("FAIL bp_drained: got %0d pending want 0", in_q.size()); end
  endtask

  task automatic test_reset_flush();
    bit found = 1'b0;
    sel = 1'b0; m_ready = 1'b1; clear_logs();
    push(1, 1'b0); push(2, 1'b0); push(3, 1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (a_busy && !a_s_ready && a_m_valid) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL rstflush_reach: got no flush window want flush with m_valid"); end
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (a_m_valid !== 1'b0 || a_busy !== 1'b0 || a_s_ready !== 1'b1 || a_m_last !== 1'b0) begin
      n_fail++; $display("FAIL rstflush_state: got m_valid %0b busy %0b s_ready %0b want 0 0 1", a_m_valid, a_busy, a_s_ready);
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (a_tap[k] !== '0) begin n_fail++; $display("FAIL rstflush_tap%0d: got %0d want 0", k, a_tap[k]); end
    end
    clear_logs();
    push(5, 1'b1);
    repeat (10) step();
    n_cmp++;
    if (got_d.size() != 6 || got_d[0] !== RW'(5) || got_l[5] !== 1'b1) begin
      n_fail++; $display("FAIL rstflush_newblk: got %0d results first %0d want 6 results first 5",
                         got_d.size(), (got_d.size() != 0) ? got_d[0] : '0);
    end
  endtask

  task automatic test_prime();
    sel = 1'b1; m_ready = 1'b1; clear_logs();
    for (int i = 1; i <= 7; i++) push(i, i == 7);
    repeat (14) step();
    n_cmp++;
    if (mv_cnt != 2 || got_d.size() != 2) begin n_fail++; $display("FAIL prime_count: got %0d results want 2", got_d.size()); end
    n_cmp++;
    if (got_d.size() < 1 || got_d[0] !== RW'(21) || got_l[0] !== 1'b0) begin
      n_fail++; $display("FAIL prime_res0: got %0d want 21", (got_d.size() > 0) ? got_d[0] : '0);
    end
    n_cmp++;
    if (got_d.size() < 2 || got_d[1] !== RW'(27) || got_l[1] !== 1'b1) begin
      n_fail++; $display("FAIL prime_res1: got %0d want 27 with last", (got_d.size() > 1) ? got_d[1] : '0);
    end
  endtask

  task automatic test_short_block();
    sel = 1'b1; m_ready = 1'b1; clear_logs();
    push(1, 1'b0); push(2, 1'b1);
    repeat (6) step();
    n_cmp++;
    if (mv_cnt != 0) begin n_fail++; $display("FAIL short_no_output: got %0d valid cycles want 0", mv_cnt); end
    n_cmp++;
    if (sb_cnt != 1) begin n_fail++; $display("FAIL short_pulse: got %0d pulses want 1", sb_cnt); end
    n_cmp++;
    if (b_busy !== 1'b0 || b_s_ready !== 1'b1 || b_tap[0] !== '0 || b_tap[1] !== '0) begin
      n_fail++; $display("FAIL short_idle: got busy %0b s_ready %0b tap0 %0d tap1 %0d want 0 1 0 0", b_busy, b_s_ready, b_tap[0], b_tap[1]);
    end
  endtask

  initial begin
    test_reset();
    test_stream_flush();
    test_backpressure();
    test_reset_flush();
    test_prime();
    test_short_block();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
